imm_gen_pipe: RTL and testbench

- Parametrised, pipelined RV immediate generator for the decode stage.
- Accepts one instruction per cycle on a valid/ready handshake and decodes its format.
- Produces an XLEN-wide sign-extended immediate, a format code, an illegal flag and a pass-through sideband tag.
- Registered output stage plus a one-entry skid buffer give full throughput under downstream back-pressure; a flush input drops in-flight entries.

---
 rtl/imm_gen_pipe_if.sv | 27 ++
 rtl/imm_gen_pipe.sv | 154 +++++++++++++++
 tb/tb_imm_gen_pipe.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: instruction-in / immediate-out handshake bundle for imm_gen_pipe.
// master = upstream/downstream environment, slave = the immediate generator.
interface imm_gen_pipe_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 8
);
    logic             i_valid;
    logic             o_ready;
    logic [31:0]      i_instruction;
    logic [TAG_W-1:0] i_tag;
    logic             o_valid;
    logic             i_ready;
    logic [XLEN-1:0]  o_imme_value;
    logic [2:0]       o_imm_type;
    logic             o_illegal;
    logic [TAG_W-1:0] o_tag;

    modport master (
        output i_valid, i_instruction, i_tag, i_ready,
        input  o_ready, o_valid, o_imme_value, o_imm_type, o_illegal, o_tag
    );

    modport slave (
        input  i_valid, i_instruction, i_tag, i_ready,
        output o_ready, o_valid, o_imme_value, o_imm_type, o_illegal, o_tag
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV immediate generator for decode.
// One registered output stage plus a one-entry skid buffer; o_ready is
// registered (skid empty) so it never depends on i_ready combinationally.
// Optional: define IMM_GEN_PIPE_ZICSR_EN to decode the CSR-immediate (Z) forms.
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 8
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_flush,
    imm_gen_pipe_if.slave  bus
);
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        T_NONE = 3'd0,
        T_I    = 3'd1,
        T_S    = 3'd2,
        T_B    = 3'd3,
        T_U    = 3'd4,
        T_J    = 3'd5,
        T_Z    = 3'd6
    } imm_type_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        imm_type_e        typ;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [31:0] inst;
    entry_t      dec;
    entry_t      out_q,   out_nxt;
    entry_t      skid_q,  skid_nxt;
    logic        out_v_q, out_v_nxt;
    logic        skid_v_q, skid_v_nxt;
    logic        ready_q, ready_nxt;
    logic        in_xfer;
    logic        out_xfer;

    assign inst = bus.i_instruction;

    // Combinational decode of the presented instruction into a result entry.
    always_comb begin
        dec     = '0;
        dec.tag = bus.i_tag;
        case (inst[6:0])
            OP_IMM, OP_LOAD, OP_JALR: begin
                dec.typ = T_I;
                dec.imm = {{(XLEN-11){inst[31]}}, inst[30:20]};
            end
            OP_STORE: begin
                dec.typ = T_S;
                dec.imm = {{(XLEN-11){inst[31]}}, inst[30:25], inst[11:7]};
            end
            OP_BRANCH: begin
                dec.typ = T_B;
                dec.imm = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                dec.typ = T_U;
                dec.imm = {{(XLEN-31){inst[31]}}, inst[30:12], 12'h000};
            end
            OP_JAL: begin
                dec.typ = T_J;
                dec.imm = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            OP_REG, OP_FENCE: begin
                dec.typ = T_NONE;
            end
`ifdef IMM_GEN_PIPE_ZICSR_EN
            OP_SYSTEM: begin
                if (inst[14]) begin
                    dec.typ = T_Z;
                    dec.imm = XLEN'(inst[19:15]);
                end
            end
`else
            OP_SYSTEM: begin
                dec.ill = 1'b1;
            end
`endif
            default: begin
                dec.ill = 1'b1;
            end
        endcase
    end

    assign in_xfer  = bus.i_valid & ready_q;
    assign out_xfer = out_v_q & bus.i_ready;

    // Next state of output stage and skid: flush wins, skid drains before new input.
    always_comb begin
        out_nxt    = out_q;
        out_v_nxt  = out_v_q;
        skid_nxt   = skid_q;
        skid_v_nxt = skid_v_q;
        if (i_flush) begin
            out_v_nxt  = 1'b0;
            skid_v_nxt = 1'b0;
        end else if (!out_v_q || out_xfer) begin
            if (skid_v_q) begin
                out_nxt    = skid_q;
                out_v_nxt  = 1'b1;
                skid_v_nxt = 1'b0;
            end else if (in_xfer) begin
                out_nxt   = dec;
                out_v_nxt = 1'b1;
            end else begin
                out_v_nxt = 1'b0;
            end
        end else if (in_xfer) begin
            skid_nxt   = dec;
            skid_v_nxt = 1'b1;
        end
        ready_nxt = ~skid_v_nxt;
    end

    // Pipeline state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_q    <= '0;
            out_v_q  <= 1'b0;
            skid_q   <= '0;
            skid_v_q <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            out_q    <= out_nxt;
            out_v_q  <= out_v_nxt;
            skid_q   <= skid_nxt;
            skid_v_q <= skid_v_nxt;
            ready_q  <= ready_nxt;
        end
    end

    assign bus.o_ready      = ready_q;
    assign bus.o_valid      = out_v_q;
    assign bus.o_imme_value = out_q.imm;
    assign bus.o_imm_type   = out_q.typ;
    assign bus.o_illegal    = out_q.ill;
    assign bus.o_tag        = out_q.tag;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: drives an XLEN=32 and an XLEN=64 instance with identical
// stimulus and checks both against a two-deep FIFO reference model.
module tb_imm_gen_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        valid;
    logic [31:0] inst;
    logic [7:0]  tag;
    logic        rdy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(8)) bus32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(8)) bus64 ();

    assign bus32.i_valid       = valid;
    assign bus32.i_instruction = inst;
    assign bus32.i_tag         = tag;
    assign bus32.i_ready       = rdy;
    assign bus64.i_valid       = valid;
    assign bus64.i_instruction = inst;
    assign bus64.i_tag         = tag;
    assign bus64.i_ready       = rdy;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) u_dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .bus(bus32.slave)
    );
    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) u_dut64 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .bus(bus64.slave)
    );

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  typ;
        logic        ill;
        logic [7:0]  tag;
    } ent_t;

    ent_t q[$];

    // Reference decode written from the format rules with signed arithmetic.
    function automatic ent_t ref_decode(logic [31:0] x, logic [7:0] t);
        ent_t   e;
        longint v;
        v     = 0;
        e.typ = 3'd0;
        e.ill = 1'b0;
        e.tag = t;
        case (x[6:0])
            7'h13, 7'h03, 7'h67: begin e.typ = 3'd1; v = $signed(x[31:20]); end
            7'h23: begin e.typ = 3'd2; v = $signed({x[31:25], x[11:7]}); end
            7'h63: begin e.typ = 3'd3; v = $signed({x[31], x[7], x[30:25], x[11:8], 1'b0}); end
            7'h37, 7'h17: begin e.typ = 3'd4; v = $signed({x[31:12], 12'h000}); end
            7'h6F: begin e.typ = 3'd5; v = $signed({x[31], x[19:12], x[20], x[30:21], 1'b0}); end
            7'h33, 7'h0F: begin end
`ifdef IMM_GEN_PIPE_ZICSR_EN
            7'h73: begin
                if (x[14]) begin e.typ = 3'd6; v = longint'(x[19:15]); end
            end
`endif
            default: e.ill = 1'b1;
        endcase
        e.imm = v;
        return e;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a two-entry in-order FIFO (head = output stage, second = skid).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else if (flush) begin
            q.delete();
        end else begin
            bit acc;
            acc = valid && (q.size() < 2);
            if (q.size() > 0 && rdy) void'(q.pop_front());
            if (acc) q.push_back(ref_decode(inst, tag));
        end
    end

    // Compare both instances against the model every cycle, mid-way between edges.
    always @(negedge clk) begin
        chk("valid32", bus32.o_valid, q.size() > 0);
        chk("ready32", bus32.o_ready, q.size() < 2);
        chk("valid64", bus64.o_valid, q.size() > 0);
        chk("ready64", bus64.o_ready, q.size() < 2);
        if (q.size() > 0) begin
            chk("imm32",  bus32.o_imme_value, {32'h0, q[0].imm[31:0]});
            chk("imm64",  bus64.o_imme_value, q[0].imm);
            chk("type32", bus32.o_imm_type, q[0].typ);
            chk("type64", bus64.o_imm_type, q[0].typ);
            chk("ill32",  bus32.o_illegal, q[0].ill);
            chk("ill64",  bus64.o_illegal, q[0].ill);
            chk("tag32",  bus32.o_tag, q[0].tag);
            chk("tag64",  bus64.o_tag, q[0].tag);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send(logic [31:0] x, logic [7:0] t);
        valid = 1'b1;
        inst  = x;
        tag   = t;
        step();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops [12];
        logic [31:0] r;
        ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37,
                7'h17, 7'h6F, 7'h33, 7'h0F, 7'h73, 7'h00};
        r = $urandom();
        if ($urandom_range(0, 11) == 11) return {r[31:7], 7'($urandom())};
        return {r[31:7], ops[$urandom_range(0, 10)]};
    endfunction

    initial begin
        logic [7:0] tcnt;
        rst_n = 1'b0;
        flush = 1'b0;
        valid = 1'b0;
        inst  = 32'h0;
        tag   = 8'h0;
        rdy   = 1'b1;
        tcnt  = 8'h0;
        repeat (3) step();

        // Reset state
        chk("rst_valid", bus32.o_valid, 0);
        chk("rst_ready", bus32.o_ready, 1);
        chk("rst_imm32", bus32.o_imme_value, 0);
        chk("rst_imm64", bus64.o_imme_value, 0);
        chk("rst_type",  bus32.o_imm_type, 0);
        chk("rst_ill",   bus32.o_illegal, 0);
        chk("rst_tag",   bus32.o_tag, 0);
        rst_n = 1'b1;
        step();

        // Directed decodes with hand-computed results
        send(32'hFFF00093, 8'h11);
        chk("i_valid",  bus32.o_valid, 1);
        chk("i_imm32",  bus32.o_imme_value, 64'h0000_0000_FFFF_FFFF);
        chk("i_imm64",  bus64.o_imme_value, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("i_type",   bus32.o_imm_type, 1);
        chk("i_ill",    bus32.o_illegal, 0);
        chk("i_tag",    bus32.o_tag, 8'h11);
        send(32'hFE000FE3, 8'h12);
        chk("b_imm32",  bus32.o_imme_value, 64'h0000_0000_FFFF_FFFE);
        chk("b_type",   bus32.o_imm_type, 3);
        send(32'h0010006F, 8'h13);
        chk("j_imm32",  bus32.o_imme_value, 64'h0000_0000_0000_0800);
        chk("j_type",   bus32.o_imm_type, 5);
        send(32'h800000B7, 8'h14);
        chk("u_imm64",  bus64.o_imme_value, 64'hFFFF_FFFF_8000_0000);
        chk("u_imm32",  bus32.o_imme_value, 64'h0000_0000_8000_0000);
        chk("u_type",   bus64.o_imm_type, 4);
        send(32'h123450B7, 8'h15);
        chk("u2_imm64", bus64.o_imme_value, 64'h0000_0000_1234_5000);
        send(32'h3002D073, 8'h16);
`ifdef IMM_GEN_PIPE_ZICSR_EN
        chk("z_imm64",  bus64.o_imme_value, 64'h5);
        chk("z_type",   bus64.o_imm_type, 6);
        chk("z_ill",    bus64.o_illegal, 0);
`else
        chk("z_imm64",  bus64.o_imme_value, 64'h0);
        chk("z_type",   bus64.o_imm_type, 0);
        chk("z_ill",    bus64.o_illegal, 1);
`endif
        send(32'h00A00033, 8'h17);
        chk("r_type",   bus32.o_imm_type, 0);
        chk("r_ill",    bus32.o_illegal, 0);
        send(32'h0000007F, 8'h18);
        chk("bad_ill",  bus32.o_illegal, 1);
        valid = 1'b0;
        step();

        // Back-pressure: tag 1 in output, tag 2 in skid, tag 3 refused
        rdy = 1'b0;
        send(32'h00100013, 8'd1);
        chk("bp_tag1",   bus32.o_tag, 1);
        chk("bp_rdy1",   bus32.o_ready, 1);
        send(32'h00200013, 8'd2);
        chk("bp_rdy2",   bus32.o_ready, 0);
        send(32'h00300013, 8'd3);
        chk("bp_hold",   bus32.o_tag, 1);
        chk("bp_rdy3",   bus32.o_ready, 0);
        rdy = 1'b1;
        step();
        chk("bp_out2",   bus32.o_tag, 2);
        step();
        chk("bp_out3",   bus32.o_tag, 3);
        valid = 1'b0;
        step();
        chk("bp_drain",  bus32.o_valid, 0);

        // Flush with both stages full and an input presented
        rdy = 1'b0;
        send(32'h00000013, 8'hA1);
        send(32'h00000013, 8'hA2);
        valid = 1'b1;
        tag   = 8'hA3;
        flush = 1'b1;
        step();
        chk("fl_valid", bus32.o_valid, 0);
        chk("fl_ready", bus32.o_ready, 1);
        flush = 1'b0;
        valid = 1'b0;
        rdy   = 1'b1;
        repeat (3) begin
            step();
            chk("fl_quiet", bus64.o_valid, 0);
        end

        // Randomised traffic with one mid-stream reset
        for (int i = 0; i < 3000; i++) begin
            valid = ($urandom_range(0, 9) < 7);
            inst  = rand_inst();
            tag   = tcnt;
            tcnt  = tcnt + 8'd1;
            rdy   = ($urandom_range(0, 9) < 6);
            flush = ($urandom_range(0, 99) < 3);
            if (i == 1500) begin
                rst_n = 1'b0;
                #1;
                chk("mid_rst_valid32", bus32.o_valid, 0);
                chk("mid_rst_valid64", bus64.o_valid, 0);
                chk("mid_rst_ready",   bus32.o_ready, 1);
                step();
                rst_n = 1'b1;
            end
            step();
        end
        valid = 1'b0;
        flush = 1'b0;
        rdy   = 1'b1;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
